// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter and sequencer in front of a
// byte-addressed data memory (combinational read, write on clock edge).
// Each transaction is granted, checked for funct3 legality, alignment and
// bounds, issued to memory for exactly one cycle and answered with a
// registered response held until the requester accepts it.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid[1:0]              per-port request valid (port 0 = LSU, port 1 = loader)
//   req_ready[1:0]              per-port request accept, at most one bit high
//   req_write[1:0]              per-port 1 = store, 0 = load
//   req_addr0/1, req_wdata0/1   byte address and store data per port
//   req_funct3_0/1              RISC-V load/store funct3 per port
//   rsp_valid[1:0], rsp_ready   per-port response handshake
//   rsp_rdata, rsp_err          load result (0 for stores/errors), reject flag
//   mem_address, mem_write_data, mem_write_enable, mem_funct3  memory request
//   mem_read_data               combinational read data from memory
module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 8192
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0]        req_write,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [31:0]       req_wdata0,
    input  logic [31:0]       req_wdata1,
    input  logic [2:0]        req_funct3_0,
    input  logic [2:0]        req_funct3_1,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_write_data,
    output logic              mem_write_enable,
    output logic [2:0]        mem_funct3,
    input  logic [31:0]       mem_read_data
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    // Bounds are compared one bit wider than the address so that an access
    // running past the top of the address space cannot wrap back into range.
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_BYTES);

    state_t            state;
    logic              last_grant;
    logic              h_grant;
    logic              h_write;
    logic              h_err;
    logic [ADDR_W-1:0] h_addr;
    logic [31:0]       h_wdata;
    logic [2:0]        h_funct3;
    logic              we_q;

    logic              g;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic [2:0]        sel_funct3;
    logic [ADDR_W:0]   size_m1;
    logic [ADDR_W:0]   end_addr;
    logic              f3_ok;
    logic              misalign;
    logic              oob;
    logic              sel_err;

    // Grant: a lone requester wins; on contention the port that did not win
    // last time is chosen.
    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        g = 1'b0;
        case (req_valid)
            2'b01:   g = 1'b0;
            2'b10:   g = 1'b1;
            2'b11:   g = ~last_grant;
            default: g = 1'b0;
        endcase
        req_ready = 2'b00;
        if (rst_n && state == IDLE && req_valid != 2'b00)
            req_ready = g ? 2'b10 : 2'b01;
    end

    assign sel_write  = g ? req_write[1] : req_write[0];
    assign sel_addr   = g ? req_addr1    : req_addr0;
    assign sel_wdata  = g ? req_wdata1   : req_wdata0;
    assign sel_funct3 = g ? req_funct3_1 : req_funct3_0;

    // Legality of the granted request, evaluated before it is accepted.
    always_comb begin
        size_m1 = '0;
        case (sel_funct3[1:0])
            2'b01:   size_m1[1:0] = 2'd1;
            2'b10:   size_m1[1:0] = 2'd3;
            default: size_m1[1:0] = 2'd0;
        endcase
        if (sel_write)
            f3_ok = sel_funct3 inside {3'b000, 3'b001, 3'b010};
        else
            f3_ok = sel_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        misalign = (sel_funct3[1:0] == 2'b01 && sel_addr[0]) ||
                   (sel_funct3[1:0] == 2'b10 && sel_addr[1:0] != 2'b00);
        end_addr = {1'b0, sel_addr} + size_m1;
        oob      = end_addr >= LIMIT;
        sel_err  = ~f3_ok | misalign | oob;
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            h_grant    <= 1'b0;
            h_write    <= 1'b0;
            h_err      <= 1'b0;
            h_addr     <= '0;
            h_wdata    <= '0;
            h_funct3   <= '0;
            we_q       <= 1'b0;
            rsp_valid  <= 2'b00;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_ready != 2'b00) begin
                        h_grant    <= g;
                        h_write    <= sel_write;
                        h_err      <= sel_err;
                        h_addr     <= sel_addr;
                        h_wdata    <= sel_wdata;
                        h_funct3   <= sel_funct3;
                        last_grant <= g;
                        // Write strobe is armed only for the single ACCESS cycle.
                        we_q       <= sel_write & ~sel_err;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    we_q      <= 1'b0;
                    rsp_rdata <= (h_write | h_err) ? 32'd0 : mem_read_data;
                    rsp_err   <= h_err;
                    rsp_valid <= h_grant ? 2'b10 : 2'b01;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready[h_grant]) begin
                        rsp_valid <= 2'b00;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory request comes straight from the holding registers, so it keeps
    // its last values outside ACCESS.
    assign mem_address      = h_addr;
    assign mem_write_data   = h_wdata;
    assign mem_funct3       = h_funct3;
    assign mem_write_enable = we_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter. A behavioural
// byte memory sits on the mem_* port; expected responses are queued when a
// request handshake is seen and compared when rsp_valid rises.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        rv [2];
    logic        rw [2];
    logic        rr [2];
    logic [31:0] ra [2];
    logic [31:0] rd [2];
    logic [2:0]  rf [2];
    logic [31:0] exp_rdata [2];
    logic        exp_err [2];

    logic [1:0]  req_valid, req_ready, req_write, rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata, mem_address, mem_write_data, mem_read_data;
    logic        rsp_err, mem_write_enable;
    logic [2:0]  mem_funct3;

    assign req_valid = {rv[1], rv[0]};
    assign req_write = {rw[1], rw[0]};
    assign rsp_ready = {rr[1], rr[0]};

    dmem_arbiter dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_addr0        (ra[0]),
        .req_addr1        (ra[1]),
        .req_wdata0       (rd[0]),
        .req_wdata1       (rd[1]),
        .req_funct3_0     (rf[0]),
        .req_funct3_1     (rf[1]),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_rdata        (rsp_rdata),
        .rsp_err          (rsp_err),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_funct3       (mem_funct3),
        .mem_read_data    (mem_read_data)
    );

    // ---------------- behavioural data memory ----------------
    logic [7:0]  mem [8192];
    logic [12:0] ma;

    always_comb begin
        ma = mem_address[12:0];
        mem_read_data = 32'd0;
        case (mem_funct3)
            3'b000:  mem_read_data = {{24{mem[ma][7]}}, mem[ma]};
            3'b100:  mem_read_data = {24'd0, mem[ma]};
            3'b001:  mem_read_data = {{16{mem[ma+13'd1][7]}}, mem[ma+13'd1], mem[ma]};
            3'b101:  mem_read_data = {16'd0, mem[ma+13'd1], mem[ma]};
            default: mem_read_data = {mem[ma+13'd3], mem[ma+13'd2], mem[ma+13'd1], mem[ma]};
        endcase
    end

    always @(posedge clk) begin
        if (mem_write_enable) begin
            mem[mem_address[12:0]] <= mem_write_data[7:0];
            if (mem_funct3[1:0] != 2'b00)
                mem[mem_address[12:0]+13'd1] <= mem_write_data[15:8];
            if (mem_funct3[1:0] == 2'b10) begin
                mem[mem_address[12:0]+13'd2] <= mem_write_data[23:16];
                mem[mem_address[12:0]+13'd3] <= mem_write_data[31:24];
            end
        end
    end

    // ---------------- checking ----------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb [$];
    int   glog [$];
    int   cyc = 0;
    int   we_count = 0;
    logic [1:0] prev_rv = 2'b00;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_write_enable) we_count <= we_count + 1;
    end

    // Latency is counted from the cycle in which the handshake is visible
    // to the cycle in which rsp_valid is first visible.
    always @(negedge clk) begin
        logic [1:0] hs;
        logic [1:0] rise;
        int         p;
        exp_t       e;
        if (!rst_n) begin
            sb.delete();
            prev_rv <= 2'b00;
        end else begin
            hs = req_valid & req_ready;
            if (hs != 2'b00) begin
                check("req_ready_onehot", $countones(req_ready), 1);
                p = hs[1] ? 1 : 0;
                glog.push_back(p);
                sb.push_back('{p, exp_rdata[p], exp_err[p], cyc});
            end
            rise = rsp_valid & ~prev_rv;
            if (rise != 2'b00) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", {30'd0, rise}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_port", {30'd0, rsp_valid}, e.port != 0 ? 32'd2 : 32'd1);
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                    check("rsp_latency", cyc - e.cyc, 2);
                end
            end
            prev_rv <= rsp_valid;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_req(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [2:0] f, input logic [31:0] er, input logic ee);
        exp_rdata[p] = er;
        exp_err[p]   = ee;
        rw[p] = w;
        ra[p] = a;
        rd[p] = d;
        rf[p] = f;
        rv[p] = 1'b1;
    endtask

    // Returns #1 after the accepting edge (DUT in ACCESS).
    task automatic wait_accept(input int p);
        bit got = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (req_ready[p]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) timeout("accept_wait");
        @(posedge clk);
        #1 rv[p] = 1'b0;
    endtask

    task automatic wait_done(input int p);
        bit got = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (rsp_valid[p] && rsp_ready[p]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) timeout("response_wait");
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] f, input logic [31:0] er, input logic ee);
        drive_req(p, w, a, d, f, er, ee);
        wait_accept(p);
        wait_done(p);
    endtask

    typedef struct {
        int          port;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        vec_t        tbl [$];
        int          w0;
        logic [31:0] cap_d;
        logic        cap_e;
        bit          got;

        tbl.push_back('{0, 1'b1, 32'h0100, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0});
        tbl.push_back('{0, 1'b0, 32'h0100, 32'h0,       3'b010, 32'hDEADBEEF, 1'b0});
        tbl.push_back('{0, 1'b1, 32'h0200, 32'h80,      3'b000, 32'h0, 1'b0});
        tbl.push_back('{0, 1'b0, 32'h0200, 32'h0,       3'b000, 32'hFFFFFF80, 1'b0});
        tbl.push_back('{0, 1'b0, 32'h0200, 32'h0,       3'b100, 32'h00000080, 1'b0});
        tbl.push_back('{1, 1'b1, 32'h0202, 32'h8001,    3'b001, 32'h0, 1'b0});
        tbl.push_back('{1, 1'b0, 32'h0202, 32'h0,       3'b001, 32'hFFFF8001, 1'b0});
        tbl.push_back('{1, 1'b0, 32'h0202, 32'h0,       3'b101, 32'h00008001, 1'b0});
        tbl.push_back('{0, 1'b0, 32'h0200, 32'h0,       3'b010, 32'h80010080, 1'b0});
        tbl.push_back('{0, 1'b0, 32'h0101, 32'h0,       3'b010, 32'h0, 1'b1});
        tbl.push_back('{0, 1'b1, 32'h0103, 32'hFFFF,    3'b001, 32'h0, 1'b1});
        tbl.push_back('{0, 1'b0, 32'h1FFE, 32'h0,       3'b010, 32'h0, 1'b1});
        tbl.push_back('{1, 1'b1, 32'h0100, 32'h12345678, 3'b100, 32'h0, 1'b1});
        tbl.push_back('{0, 1'b0, 32'h0100, 32'h0,       3'b011, 32'h0, 1'b1});
        tbl.push_back('{0, 1'b1, 32'h1FFE, 32'hAAAA,    3'b001, 32'h0, 1'b0});
        tbl.push_back('{1, 1'b0, 32'h1FFE, 32'h0,       3'b101, 32'h0000AAAA, 1'b0});
        tbl.push_back('{1, 1'b0, 32'h1FFC, 32'h0,       3'b010, 32'hAAAA0000, 1'b0});
        tbl.push_back('{0, 1'b1, 32'h2000, 32'h55,      3'b000, 32'h0, 1'b1});
        tbl.push_back('{0, 1'b0, 32'h2000, 32'h0,       3'b010, 32'h0, 1'b1});
        tbl.push_back('{0, 1'b0, 32'hFFFFFFFF, 32'h0,   3'b100, 32'h0, 1'b1});
        tbl.push_back('{0, 1'b0, 32'h0100, 32'h0,       3'b010, 32'hDEADBEEF, 1'b0});
        tbl.push_back('{0, 1'b0, 32'h0104, 32'h0,       3'b010, 32'h0, 1'b0});
        tbl.push_back('{0, 1'b0, 32'h0000, 32'h0,       3'b010, 32'h0, 1'b0});

        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
        for (int p = 0; p < 2; p++) begin
            rv[p] = 1'b0; rw[p] = 1'b0; rr[p] = 1'b1;
            ra[p] = '0;   rd[p] = '0;   rf[p] = '0;
            exp_rdata[p] = '0; exp_err[p] = 1'b0;
        end

        // Reset state
        rst_n = 1'b0;
        #22;
        check("reset_req_ready", {30'd0, req_ready}, 32'd0);
        check("reset_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("reset_mem_we", {31'd0, mem_write_enable}, 32'd0);
        check("reset_mem_addr", mem_address, 32'd0);
        check("reset_mem_wdata", mem_write_data, 32'd0);
        check("reset_mem_funct3", {29'd0, mem_funct3}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Round-robin with both ports requesting: port 0 wins first after reset
        fork
            begin
                issue(0, 1'b0, 32'h1FFC, 32'h0, 3'b010, 32'h0, 1'b0);
                issue(0, 1'b0, 32'h0000, 32'h0, 3'b010, 32'h0, 1'b0);
                issue(0, 1'b0, 32'h0004, 32'h0, 3'b001, 32'h0, 1'b0);
            end
            begin
                issue(1, 1'b0, 32'h1FFF, 32'h0, 3'b100, 32'h0, 1'b0);
                issue(1, 1'b0, 32'h0008, 32'h0, 3'b010, 32'h0, 1'b0);
                issue(1, 1'b0, 32'h000C, 32'h0, 3'b000, 32'h0, 1'b0);
            end
        join
        check("rr_grant_count", glog.size(), 6);
        for (int i = 0; i < glog.size(); i++)
            check($sformatf("rr_grant_%0d", i), glog[i], i % 2);

        // Table-driven functional, sign/size, error and boundary vectors
        foreach (tbl[i]) begin
            w0 = we_count;
            issue(tbl[i].port, tbl[i].write, tbl[i].addr, tbl[i].wdata, tbl[i].f3,
                  tbl[i].exp_rdata, tbl[i].exp_err);
            check($sformatf("we_pulses_vec%0d", i), we_count - w0,
                  (tbl[i].write && !tbl[i].exp_err) ? 1 : 0);
        end

        // Response back-pressure: port 0 stalled 5 cycles while port 1 waits
        rr[0] = 1'b0;
        drive_req(0, 1'b0, 32'h0100, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0);
        wait_accept(0);
        drive_req(1, 1'b0, 32'h0200, 32'h0, 3'b100, 32'h00000080, 1'b0);
        got = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (rsp_valid[0]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) timeout("stall_rsp_wait");
        cap_d = rsp_rdata;
        cap_e = rsp_err;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            check("stall_rsp_valid", {30'd0, rsp_valid}, 32'd1);
            check("stall_rsp_rdata", rsp_rdata, cap_d);
            check("stall_rsp_err", {31'd0, rsp_err}, {31'd0, cap_e});
            check("stall_req_ready", {30'd0, req_ready}, 32'd0);
        end
        @(posedge clk);
        #1 rr[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("release_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("release_req_ready", {30'd0, req_ready}, 32'd2);
        @(posedge clk);
        #1 rv[1] = 1'b0;
        wait_done(1);

        // Reset during ACCESS of a store: write dropped, no response
        issue(0, 1'b1, 32'h0300, 32'h11223344, 3'b010, 32'h0, 1'b0);
        drive_req(0, 1'b1, 32'h0300, 32'hCAFEF00D, 3'b010, 32'h0, 1'b0);
        wait_accept(0);
        check("access_we_before_reset", {31'd0, mem_write_enable}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_req_ready", {30'd0, req_ready}, 32'd0);
        check("midrst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("midrst_rsp_rdata", rsp_rdata, 32'd0);
        check("midrst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("midrst_mem_we", {31'd0, mem_write_enable}, 32'd0);
        check("midrst_mem_addr", mem_address, 32'd0);
        check("midrst_mem_wdata", mem_write_data, 32'd0);
        check("midrst_mem_funct3", {29'd0, mem_funct3}, 32'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_reset_no_rsp", {30'd0, rsp_valid}, 32'd0);
        @(posedge clk);
        #1;
        issue(0, 1'b0, 32'h0300, 32'h0, 3'b010, 32'h11223344, 1'b0);

        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the byte-addressed data memory (combinational read, write on clock edge, funct3-coded size/sign).
- Port 0 serves the core load/store unit. Port 1 serves the debug/program loader.
- Each transaction is granted round-robin, then checked for alignment, bounds and funct3 legality, issued to memory for one cycle, and returned as a registered response under a valid/ready handshake.

Parameters:
- ADDR_W, 32, address width of both requester ports and the memory port.
- MEM_BYTES, 8192, memory size in bytes; the last legal byte is MEM_BYTES-1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  per-port request valid; bit i belongs to port i.
- req_ready  out  2  per-port request accept; at most one bit high.
- req_write  in  2  per-port 1 = store, 0 = load.
- req_addr0 / req_addr1  in  32 each  byte address.
- req_wdata0 / req_wdata1  in  32 each  store data; low bytes are used per size.
- req_funct3_0 / req_funct3_1  in  3 each  RISC-V load/store funct3.
- rsp_valid  out  2  per-port response valid.
- rsp_ready  in  2  per-port response accept.
- rsp_rdata  out  32  load result; 0 for stores and for errors.
- rsp_err  out  1  1 = access rejected.
- mem_address  out  32  to memory.
- mem_write_data  out  32  to memory.
- mem_write_enable  out  1  to memory.
- mem_funct3  out  3  to memory.
- mem_read_data  in  32  from memory; combinational.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, last_grant = 1, so port 0 wins first.
  - All outputs 0: req_ready, rsp_valid, rsp_rdata, rsp_err, mem_write_enable, mem_address, mem_write_data, mem_funct3.
  - An in-flight transaction is dropped and its write is not performed; no response is produced after reset.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If exactly one req_valid is high, that port is granted.
  - If both are high, the port not equal to last_grant is granted.
  - req_ready[g] is asserted combinationally in IDLE only.
  - On the accepting edge: latch addr, wdata, funct3, write and g into holding registers; set last_grant = g; evaluate the error; go to ACCESS.
- Error conditions (any one sets err):
  - funct3 illegal: stores accept only 000/001/010; loads accept 000/001/010/100/101.
  - Misaligned: size 2 with addr[0]=1; size 4 with addr[1:0]≠0.
  - Out of bounds: addr + size - 1 ≥ MEM_BYTES, evaluated in ADDR_W+1 bits so wrap-around cannot pass.
- ACCESS (exactly one cycle):
  - mem_address, mem_write_data and mem_funct3 are driven from the holding registers.
  - mem_write_enable = write & ~err, high for this cycle only.
  - On the exit edge: rsp_rdata = (write | err) ? 0 : mem_read_data; rsp_err = err; go to RESP.
  - With err set, memory is untouched.
- RESP:
  - rsp_valid[g] = 1; rsp_rdata and rsp_err are held stable.
  - When rsp_ready[g] = 1, clear rsp_valid and go to IDLE.
  - No new request is accepted while in RESP.
- Latency and throughput:
  - Accept edge to rsp_valid = 2 cycles.
  - Minimum of 3 cycles per transaction when rsp_ready is tied high.
- mem_* outputs hold their last values outside ACCESS; mem_write_enable is 0 outside ACCESS.
- A request dropped by the requester before its accept is ignored. Requesters must hold their request fields stable while req_valid is high.
- Round-robin fairness: with both ports continuously requesting, grants alternate 0,1,0,1.

Test Plan:
- Port 0 SW addr 0x100 data 0xDEADBEEF, then port 0 LW 0x100 -> rsp_rdata 0xDEADBEEF, rsp_err 0; rsp_valid rises exactly 2 cycles after the accept edge.
- SB 0x200 data 0x80, then LB 0x200 -> 0xFFFFFF80; LBU 0x200 -> 0x00000080. SH 0x202 data 0x8001, then LH -> 0xFFFF8001; LHU -> 0x00008001.
- Both ports valid every cycle with rsp_ready high -> grants 0,1,0,1; each response appears on the granted port only.
- LW 0x101, SH 0x103, LW 0x1FFE, and store funct3=100 -> rsp_err 1, rsp_rdata 0, mem_write_enable never asserted; memory contents unchanged on readback.
- Hold rsp_ready low for 5 cycles in RESP -> rsp_valid and data stable, req_ready 0 on both ports; on release, return to IDLE the next cycle.
- Assert rst_n low during ACCESS of SW 0x300 -> all outputs 0 immediately, no response, and a later LW 0x300 returns the prior contents.
